uart_rx_os16: RTL and testbench
===============================

Name: uart_rx_os16

Overview:
- UART receiver with 16x oversampling; the downstream stage of the serial transmitter. Consumes the serial line and delivers bytes in parallel.
- Frame format is 8N1, LSB first: 1 start bit, 8 data bits, 1 stop bit.
- Produces a one-cycle byte-valid strobe and a framing-error strobe for the host logic.

Parameters:
- freq, 100_000_000, system clock frequency in Hz.
- baud_rate, 9600, line rate in bit/s.
- Derived, local, not overridable: DIV = freq/(baud_rate*16). Default DIV = 651.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last received byte; holds its value until the next good frame.
- rx_valid  output  1  one-clk pulse; rx_data is valid in the same cycle.
- frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- busy  output  1  high while the state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - rx_data=8'h00, rx_valid=0, frame_err=0, busy=0.
  - State=IDLE, all counters=0, synchroniser flops=1.
- Synchroniser: rx passes through 2 flops; rxs is the synchronised value. Input-to-rxs latency is 2 clk.
- Tick generator:
  - Free-running counter 0..DIV-1, reset to 0.
  - tick=1 for one clk when counter==DIV-1, i.e. 16 ticks per bit.
- os_cnt: 4-bit, counts ticks within a bit; wraps 15->0.
- bit_cnt: 3-bit, counts data bits.
- IDLE:
  - On tick with rxs==0: go to START, os_cnt=0.
  - Otherwise stay in IDLE.
- START:
  - On each tick, os_cnt++.
  - At os_cnt==7: if rxs==1 (glitch), return to IDLE with no output. Otherwise continue.
  - At os_cnt==15: go to DATA, os_cnt=0, bit_cnt=0.
- DATA:
  - Sample rxs on ticks at os_cnt==7, 8 and 9. The bit value is the majority of the 3 samples.
  - At os_cnt==15: shift the bit into shreg[7] (right shift, LSB first).
  - If bit_cnt==7, go to STOP; else bit_cnt++.
- STOP:
  - Majority-sample at os_cnt 7/8/9.
  - At the tick with os_cnt==9:
    - Stop bit 1: rx_data<=shreg, rx_valid=1 in the next clk, go to IDLE.
    - Stop bit 0: frame_err=1 in the next clk, rx_data unchanged, go to BREAK.
  - Stop-bit acceptance is at mid-bit, so a back-to-back start bit is never missed.
- BREAK: stay until rxs==1 on a tick, then go to IDLE. A held-low line yields exactly one frame_err.
- rx_valid and frame_err are mutually exclusive and never high for more than one clk.
- Asserting rst mid-frame aborts the frame immediately. No strobe is produced and rx_data returns to 8'h00.
- Timing tolerance: a bit period of 16*DIV clk is accepted with up to ±4% rate mismatch. The transmitter's 10417-clk bit is well within this.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1: an even-parity bit is inserted between D7 and STOP, in an extra PARITY state sampled like a data bit.
  - Adds output port parity_err (1 bit, reset 0). It pulses in the same clk as rx_valid when the XOR of data and parity is 1. rx_data is still updated.
  - A framing error takes precedence: in that case only frame_err pulses.
- Undefined: no PARITY state and no parity_err port; 8N1 only.

Decomposition:
- Package uart_pkg:
  - enum rx_state_t {IDLE, START, DATA, PARITY, STOP, BREAK}, 3-bit.
  - localparam OS_RATE=16.
  - localparams OS_MID=7, OS_LAST=15.
- Sub-module uart_baud_tick, shared with future TX rework:
  - Parameters freq, baud_rate, os_rate.
  - Ports clk, rst, tick.
- Majority vote is inline, not a module.

Test Plan:
- 8N1 frame 8'h99 at 104.17 us/bit: exactly one rx_valid with rx_data=8'h99, frame_err=0. rx_valid occurs 9.56 bit periods (±1 tick) after the start edge.
- Loopback through the existing transmitter, bytes 8'h99, 8'h00, 8'hFF, 8'hA5, back-to-back: 4 rx_valid pulses with matching data, no frame_err.
- Low glitch of 5 ticks on idle line: busy pulses, then returns to IDLE with no strobe. A subsequent 8'h3C frame is received correctly.
- Frame 8'h55 with stop bit driven 0, then line held low 3 bit times: one frame_err, no rx_valid, rx_data keeps its prior value. After rx returns high, next frame 8'h12 is received.
- rst asserted after the 4th data bit of 8'hF0: all outputs 0 immediately. Re-sent 8'hF0 is received as 8'hF0.
- With UART_RX_PARITY_EN, send 8'h07 with parity bit 0 (wrong): rx_valid and parity_err together, rx_data=8'h07. Repeat with parity bit 1: parity_err stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_t;

    localparam int unsigned OS_RATE = 16;
    localparam logic [3:0]  OS_MID  = 4'd7;
    localparam logic [3:0]  OS_LAST = 4'd15;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick: one-clk pulse every freq/(baud_rate*os_rate) clocks.
module uart_baud_tick #(
    parameter int unsigned freq      = 100_000_000,
    parameter int unsigned baud_rate = 9600,
    parameter int unsigned os_rate   = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned DIV = freq / (baud_rate * os_rate);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver, 8N1 LSB first, 16x oversampling with a 3-sample majority vote.
// Define UART_RX_PARITY_EN for 8E1 frames and an extra parity_err strobe.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int unsigned freq      = 100_000_000,
    parameter int unsigned baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);
    localparam logic [3:0] OS_LATE = OS_MID + 4'd2;

    logic       tick;
    logic       rx_meta_q, rxs_q;
    rx_state_t  state_q, state_d;
    logic [3:0] os_cnt_q, os_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] votes_q, votes_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       sample_win, stop_bit;
`ifdef UART_RX_PARITY_EN
    logic       par_q, par_d;
    logic       parity_err_q, parity_err_d;
`endif

    uart_baud_tick #(
        .freq      (freq),
        .baud_rate (baud_rate),
        .os_rate   (OS_RATE)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign sample_win = (os_cnt_q == OS_MID) || (os_cnt_q == OS_MID + 4'd1) ||
                        (os_cnt_q == OS_LATE);
    // Stop is decided on the third sample tick, so that sample comes straight from rxs.
    assign stop_bit = maj3({votes_q[1:0], rxs_q});

    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        votes_d     = votes_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        if (tick) begin
            if (sample_win) begin
                votes_d = {votes_q[1:0], rxs_q};
            end
            case (state_q)
                StIdle: begin
                    if (!rxs_q) begin
                        state_d  = StStart;
                        os_cnt_d = '0;
                    end
                end
                StStart: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == OS_MID && rxs_q) begin
                        state_d = StIdle;
                    end else if (os_cnt_q == OS_LAST) begin
                        state_d   = StData;
                        os_cnt_d  = '0;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == OS_LAST) begin
                        shreg_d = {maj3(votes_q), shreg_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == OS_LAST) begin
                        par_d   = maj3(votes_q);
                        state_d = StStop;
                    end
                end
`endif
                StStop: begin
                    os_cnt_d = os_cnt_q + 4'd1;
                    if (os_cnt_q == OS_LATE) begin
                        if (stop_bit) begin
                            rx_data_d  = shreg_q;
                            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = ^{shreg_q, par_q};
`endif
                            state_d = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StBreak;
                        end
                    end
                end
                StBreak: begin
                    if (rxs_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= StIdle;
            os_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            votes_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx;
            rxs_q       <= rx_meta_q;
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            votes_q     <= votes_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed plus randomized bench for uart_rx_os16, using a reduced divider (DIV=8).
`timescale 1ns/1ps
module tb_uart_rx_os16;
    localparam int unsigned FREQ = 1_280_000;
    localparam int unsigned BAUD = 10_000;
    localparam int unsigned DIV  = FREQ / (BAUD * 16);
    localparam int unsigned BIT  = DIV * 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned EXTRA_TICKS = 16;
`else
    localparam int unsigned EXTRA_TICKS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int ferr_cnt = 0, both_cnt = 0, long_cnt = 0, perr_cnt = 0, perr_stray = 0;
    int valid_cyc = 0;
    logic busy_seen = 1'b0;
    logic prev_v = 1'b0, prev_f = 1'b0;

    always #5 clk = ~clk;

    uart_rx_os16 #(
        .freq      (FREQ),
        .baud_rate (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rx_valid) begin
            got_q.push_back(rx_data);
            valid_cyc = cyc;
        end
        if (frame_err) ferr_cnt++;
        if (rx_valid && frame_err) both_cnt++;
        if ((rx_valid && prev_v) || (frame_err && prev_f)) long_cnt++;
        if (busy) busy_seen = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) begin
            perr_cnt++;
            if (!rx_valid) perr_stray++;
        end
`endif
        prev_v = rx_valid;
        prev_f = frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int val, input int lo, input int hi);
        n_chk++;
        assert (val >= lo && val <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
        end
    endtask

    task automatic expect_bytes(input string tag, input logic [7:0] want[$]);
        check({tag, "_count"}, got_q.size(), want.size());
        for (int i = 0; i < want.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'h0, got_q[i]}, {24'h0, want[i]});
        end
        got_q.delete();
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        wait_clks(n * BIT);
    endtask

    task automatic send_bit(input logic b, input int bclk);
        rx = b;
        wait_clks(bclk);
    endtask

    // Frame with correct (even) parity when the parity build is selected.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int bclk);
        send_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) send_bit(d[i], bclk);
`ifdef UART_RX_PARITY_EN
        send_bit(^d, bclk);
`endif
        send_bit(stop, bclk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic par, input int bclk);
        send_bit(1'b0, bclk);
        for (int i = 0; i < 8; i++) send_bit(d[i], bclk);
        send_bit(par, bclk);
        send_bit(1'b1, bclk);
    endtask
`endif

    initial begin
        int edge_cyc;
        int f0;
        logic [7:0] last_good;
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(5);
        check("reset_rx_data", {24'h0, rx_data}, 32'h0);
        check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        idle_bits(2);

        // Single nominal frame and its latency from the start edge.
        edge_cyc = cyc;
        send_frame(8'h99, 1'b1, BIT);
        idle_bits(1);
        exp_q = '{8'h99};
        expect_bytes("single_99", exp_q);
        check("single_99_ferr", ferr_cnt, 0);
        check_range("single_99_latency", valid_cyc - edge_cyc,
                    (152 + EXTRA_TICKS) * DIV, (155 + EXTRA_TICKS) * DIV + 3);

        // Back-to-back frames, no idle between them.
        send_frame(8'h99, 1'b1, BIT);
        send_frame(8'h00, 1'b1, BIT);
        send_frame(8'hFF, 1'b1, BIT);
        send_frame(8'hA5, 1'b1, BIT);
        idle_bits(1);
        exp_q = '{8'h99, 8'h00, 8'hFF, 8'hA5};
        expect_bytes("b2b", exp_q);
        check("b2b_ferr", ferr_cnt, 0);

        // Short low glitch must be rejected as a false start.
        busy_seen = 1'b0;
        rx = 1'b0;
        wait_clks(5 * DIV);
        idle_bits(2);
        check("glitch_busy_seen", {31'h0, busy_seen}, 32'h1);
        check("glitch_busy_end", {31'h0, busy}, 32'h0);
        check("glitch_no_valid", got_q.size(), 0);
        check("glitch_no_ferr", ferr_cnt, 0);
        send_frame(8'h3C, 1'b1, BIT);
        idle_bits(1);
        exp_q = '{8'h3C};
        expect_bytes("after_glitch", exp_q);

        // Bad stop bit followed by a held-low line: exactly one framing error.
        send_frame(8'h55, 1'b0, BIT);
        rx = 1'b0;
        wait_clks(3 * BIT);
        idle_bits(2);
        check("break_ferr_cnt", ferr_cnt, 1);
        check("break_no_valid", got_q.size(), 0);
        check("break_rx_data_kept", {24'h0, rx_data}, 32'h3C);
        send_frame(8'h12, 1'b1, BIT);
        idle_bits(1);
        exp_q = '{8'h12};
        expect_bytes("after_break", exp_q);

        // Reset in the middle of a frame aborts it at once.
        send_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) send_bit(1'b0, BIT);  // low nibble of 8'hF0
        rst = 1'b1;
        #1;
        check("midrst_rx_data", {24'h0, rx_data}, 32'h0);
        check("midrst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        rx = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        idle_bits(2);
        check("midrst_no_strobe", got_q.size(), 0);
        send_frame(8'hF0, 1'b1, BIT);
        idle_bits(1);
        exp_q = '{8'hF0};
        expect_bytes("resend_f0", exp_q);
        last_good = 8'hF0;

`ifdef UART_RX_PARITY_EN
        // Wrong parity still delivers the byte, flagged in the same cycle.
        send_frame_par(8'h07, 1'b0, BIT);
        idle_bits(1);
        check("par_bad_perr", perr_cnt, 1);
        exp_q = '{8'h07};
        expect_bytes("par_bad", exp_q);
        send_frame_par(8'h07, 1'b1, BIT);
        idle_bits(1);
        check("par_good_perr", perr_cnt, 1);
        exp_q = '{8'h07};
        expect_bytes("par_good", exp_q);
        check("par_stray", perr_stray, 0);
        last_good = 8'h07;
`endif

        // Random bytes, bit periods within +-2.4 %, random gaps and stop bits.
        exp_q.delete();
        f0 = ferr_cnt;
        for (int n = 0; n < 14; n++) begin
            logic [7:0] d;
            logic       stop;
            int         bclk;
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            bclk = BIT - 3 + $urandom_range(0, 6);
            send_frame(d, stop, bclk);
            if (stop) begin
                exp_q.push_back(d);
                last_good = d;
                rx = 1'b1;
                wait_clks($urandom_range(0, BIT));
            end else begin
                f0++;
                idle_bits(1);
            end
        end
        idle_bits(2);
        expect_bytes("random", exp_q);
        check("random_ferr", ferr_cnt, f0);
        check("random_last_data", {24'h0, rx_data}, {24'h0, last_good});
`ifdef UART_RX_PARITY_EN
        check("random_perr", perr_cnt, 1);
`endif
        check("strobes_exclusive", both_cnt, 0);
        check("strobes_one_clk", long_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
